// File: rtl/vram_write_arbiter_pkg.sv
// Shared widths, FSM encoding and helpers for the VRAM write arbiter.
// `MEMORY_SIZE_BITS normally comes from the shared header; a default is supplied here.
`ifndef MEMORY_SIZE_BITS
`define MEMORY_SIZE_BITS 15
`endif

package vram_write_arbiter_pkg;

    localparam int ADDR_W  = `MEMORY_SIZE_BITS;
    localparam int COLOR_W = 3;
    localparam int IDX_W   = 2;   // wide enough for up to 4 requesters

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [3:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vram_write_arbiter_if.sv
// Requester-side and video-memory-side signals of the VRAM write arbiter.
interface vram_write_arbiter_if
    import vram_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*ADDR_W-1:0]  addr_in;
    logic [NUM_REQ*COLOR_W-1:0] color_in;
    logic [NUM_REQ-1:0]         wen_in;
    logic [NUM_REQ-1:0]         grant;
    logic [ADDR_W-1:0]          address;
    logic [COLOR_W-1:0]         color;
    logic                       print_enable;
    logic                       busy;

    modport master (
        output req, addr_in, color_in, wen_in,
        input  grant, address, color, print_enable, busy
    );

    modport slave (
        input  req, addr_in, color_in, wen_in,
        output grant, address, color, print_enable, busy
    );
endinterface

// File: rtl/vram_write_arbiter_arb_pick.sv
// Combinational winner selection: first requester found searching upward from ptr.
module arb_pick
    import vram_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);
    logic             found;
    logic [IDX_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vram_write_arbiter.sv
// Arbitrates NUM_REQ writers onto the single video-memory write port.
// Define VRAM_ARB_RR_EN for round-robin selection; fixed priority otherwise.
module vram_write_arbiter
    import vram_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 Clck,
    input  logic                 Reset,
    vram_write_arbiter_if.slave  bus
);
    localparam logic [1:0] GAP_LOAD = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ADDR_W-1:0]  address_q, address_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               pe_q, pe_d;
    logic [1:0]         gap_q, gap_d;
    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   search_ptr;

    assign pick_idx = onehot_to_idx(4'(pick));
    assign win_idx  = onehot_to_idx(4'(grant_q));

`ifdef VRAM_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q;

    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            ptr_q <= '0;
        end else if (state_q == ST_IDLE && |bus.req) begin
            ptr_q <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    assign search_ptr = ptr_q;
`else
    assign search_ptr = '0;
`endif

    arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (bus.req),
        .ptr    (search_ptr),
        .winner (pick)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        address_d = address_q;
        color_d   = color_q;
        pe_d      = 1'b0;
        gap_d     = gap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    grant_d = pick;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (|(bus.req & grant_q)) begin
                    address_d = bus.addr_in[int'(win_idx)*ADDR_W +: ADDR_W];
                    color_d   = bus.color_in[int'(win_idx)*COLOR_W +: COLOR_W];
                    pe_d      = bus.wen_in[win_idx];
                end else begin
                    // Owner released: address/colour hold, strobe and grant drop together.
                    grant_d = '0;
                    gap_d   = GAP_LOAD;
                    state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == 2'd0) state_d = ST_IDLE;
                else               gap_d   = gap_q - 2'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: every register, including the datapath, is reset so a mid-burst reset leaves no stale write.
    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            address_q <= '0;
            color_q   <= '0;
            pe_q      <= 1'b0;
            gap_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            address_q <= address_d;
            color_q   <= color_d;
            pe_q      <= pe_d;
            gap_q     <= gap_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.address      = address_q;
    assign bus.color        = color_q;
    assign bus.print_enable = pe_q;
    assign bus.busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed-vector bench for vram_write_arbiter (NUM_REQ=3, GAP_CYCLES=1).
module tb_vram_write_arbiter;
    import vram_write_arbiter_pkg::*;

    logic Clck;
    logic Reset;
    int   n_cmp;
    int   n_bad;

    vram_write_arbiter_if #(.NUM_REQ(3)) bus ();

    vram_write_arbiter #(.NUM_REQ(3), .GAP_CYCLES(1)) dut (
        .Clck  (Clck),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clck = 1'b0;
    always #5 Clck = ~Clck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clck);
        #1;
    endtask

    task automatic set_src(input int i, input int a, input int c, input logic w);
        bus.addr_in[i*ADDR_W +: ADDR_W]    = ADDR_W'(a);
        bus.color_in[i*COLOR_W +: COLOR_W] = COLOR_W'(c);
        bus.wen_in[i]                      = w;
    endtask

    task automatic drain();
        bus.req = 3'b000;
        tick();
        tick();
        check("drain_idle", bus.busy, 1'b0);
    endtask

    // Invariants: grant never multi-hot, no strobe without a grant.
    always @(negedge Clck) begin
        if (Reset) begin
            check("grant_onehot", ($countones(bus.grant) <= 1), 1'b1);
            check("pe_no_grant", (bus.print_enable && bus.grant == '0), 1'b0);
        end
    end

    logic [2:0] order [4];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        Reset = 1'b0;
        bus.req = '0;
        bus.addr_in = '0;
        bus.color_in = '0;
        bus.wen_in = '0;
`ifdef VRAM_ARB_RR_EN
        order = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        order = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        #12;
        check("rst_grant", bus.grant, 0);
        check("rst_addr", bus.address, 0);
        check("rst_color", bus.color, 0);
        check("rst_pe", bus.print_enable, 0);
        check("rst_busy", bus.busy, 0);
        Reset = 1'b1;

        // Simultaneous requests, each owner releases after 4 grant cycles.
        for (int r = 0; r < 4; r++) begin
            bus.req = 3'b111;
            tick();
            check("sim_grant", bus.grant, order[r]);
            check("sim_busy", bus.busy, 1);
            for (int k = 0; k < 3; k++) begin
                tick();
                check("sim_hold", bus.grant, order[r]);
            end
            bus.req = 3'b111 & ~order[r];
            tick();
            check("sim_gap_grant", bus.grant, 0);
            check("sim_gap_busy", bus.busy, 1);
            bus.req = 3'b111;
            tick();
            check("sim_idle_busy", bus.busy, 0);
        end
        bus.req = 3'b000;
        tick();
        check("idle_noreq_grant", bus.grant, 0);
        check("idle_noreq_pe", bus.print_enable, 0);

        // Single requester, addresses 5,6,7.
        set_src(0, 5, 1, 1'b1);
        bus.req = 3'b001;
        tick();
        check("single_grant", bus.grant, 3'b001);
        check("single_first_pe", bus.print_enable, 0);
        for (int a = 5; a <= 7; a++) begin
            set_src(0, a, 1, 1'b1);
            tick();
            check("single_addr", bus.address, a);
            check("single_pe", bus.print_enable, 1);
        end
        bus.req = 3'b000;
        tick();
        check("single_rel_grant", bus.grant, 0);
        check("single_rel_pe", bus.print_enable, 0);
        check("single_rel_addr", bus.address, 7);
        check("single_gap_busy", bus.busy, 1);
        tick();
        check("single_idle_busy", bus.busy, 0);

        // No preemption of requester 2.
        set_src(2, 30, 2, 1'b1);
        bus.req = 3'b100;
        tick();
        check("np_grant", bus.grant, 3'b100);
        bus.req = 3'b101;
        tick();
        check("np_keep1", bus.grant, 3'b100);
        check("np_addr", bus.address, 30);
        tick();
        check("np_keep2", bus.grant, 3'b100);
        bus.req = 3'b001;
        tick();
        check("np_gap", bus.grant, 0);
        tick();
        check("np_idle", bus.grant, 0);
        tick();
        check("np_next", bus.grant, 3'b001);
        drain();

        // Non-granted requester's write data is ignored.
        set_src(0, 20, 3, 1'b1);
        set_src(1, 99, 5, 1'b1);
        bus.req = 3'b001;
        tick();
        check("ign_grant", bus.grant, 3'b001);
        tick();
        check("ign_addr", bus.address, 20);
        check("ign_color", bus.color, 3);
        check("ign_pe", bus.print_enable, 1);
        bus.wen_in[0] = 1'b0;
        tick();
        check("ign_pe_off", bus.print_enable, 0);
        check("ign_not99", (bus.address == 99), 0);
        drain();

        // Asynchronous reset in the middle of a burst.
        set_src(0, 12, 6, 1'b1);
        set_src(1, 0, 0, 1'b0);
        bus.req = 3'b001;
        tick();
        tick();
        check("ar_addr", bus.address, 12);
        check("ar_pe", bus.print_enable, 1);
        #2 Reset = 1'b0;
        #1;
        check("ar_grant0", bus.grant, 0);
        check("ar_pe0", bus.print_enable, 0);
        check("ar_addr0", bus.address, 0);
        check("ar_color0", bus.color, 0);
        check("ar_busy0", bus.busy, 0);
        bus.req = 3'b010;
        tick();
        check("ar_held", bus.grant, 0);
        #2 Reset = 1'b1;
        tick();
        check("ar_regrant", bus.grant, 3'b010);
        drain();

        // One-cycle request: grant for exactly one cycle, no write.
        set_src(1, 40, 4, 1'b1);
        bus.req = 3'b010;
        tick();
        check("drop_grant", bus.grant, 3'b010);
        check("drop_busy", bus.busy, 1);
        check("drop_pe", bus.print_enable, 0);
        bus.req = 3'b000;
        tick();
        check("drop_grant0", bus.grant, 0);
        check("drop_pe0", bus.print_enable, 0);
        check("drop_gap_busy", bus.busy, 1);
        tick();
        check("drop_idle_busy", bus.busy, 0);
        check("drop_idle_pe", bus.print_enable, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vram_write_arbiter.md
VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of write requesters; supported range 2..4.
REQ-002 Parameter GAP_CYCLES, default 1: dead cycles after each grant release; supported range 0..3.
REQ-003 Port Clck  in  1: sole clock; all state changes on its rising edge.
REQ-004 Port Reset  in  1: asynchronous, active-low reset.
REQ-005 Port req  in  NUM_REQ: bit i high means requester i wants the memory write port.
REQ-006 Port addr_in  in  NUM_REQ*`MEMORY_SIZE_BITS: flattened addresses; requester i occupies slice i.
REQ-007 Port color_in  in  NUM_REQ*3: flattened 3-bit colours; requester i occupies slice i.
REQ-008 Port wen_in  in  NUM_REQ: per-requester write enable (each requester's print_enable).
REQ-009 Port grant  out  NUM_REQ: one-hot grant; all zero when no requester owns the port.
REQ-010 Port address  out  `MEMORY_SIZE_BITS: registered address to video memory.
REQ-011 Port color  out  3: registered colour to video memory.
REQ-012 Port print_enable  out  1: registered write strobe to video memory.
REQ-013 Port busy  out  1: high in GRANT and GAP states.

Function
REQ-014 FSM states: IDLE, GRANT, GAP.
REQ-015 IDLE with req != 0: select a winner; next edge sets grant to one-hot(winner) and enters GRANT.
REQ-016 IDLE with req == 0: grant stays 0 and print_enable stays 0.
REQ-017 GRANT, while req[winner] is high: each edge registers addr_in[winner] to address, color_in[winner] to color and wen_in[winner] to print_enable (1-cycle latency).
REQ-018 GRANT with req[winner] low: on that edge, grant clears, print_enable goes 0, address and color hold, and the FSM enters GAP (or IDLE directly if GAP_CYCLES == 0).
REQ-019 GAP lasts exactly GAP_CYCLES cycles with print_enable 0 and grant 0, then returns to IDLE; requests seen during GAP are evaluated only on return to IDLE.
REQ-020 Grant is never preempted; a requester keeps the port until it drops req, whatever other requests are pending.
REQ-021 wen_in, addr_in and color_in of non-granted requesters are ignored.
REQ-022 A grant whose req drops in the first GRANT cycle produces zero writes and follows REQ-018.
REQ-023 grant is never multi-hot; print_enable is never high while grant is zero.
REQ-024 A requester that re-asserts req immediately after release competes normally; it gets no automatic re-grant.

Reset
REQ-025 Reset low asynchronously forces: FSM to IDLE, grant 0, address 0, color 0, print_enable 0, busy 0, gap counter 0, round-robin pointer 0.
REQ-026 Reset mid-GRANT aborts the burst with no further write; after release, arbitration restarts from IDLE.

Configuration
REQ-027 With VRAM_ARB_RR_EN defined: round-robin selection; search starts at the pointer; the pointer becomes (winner+1) mod NUM_REQ at each grant.
REQ-028 Without VRAM_ARB_RR_EN: fixed priority, lowest index wins; no pointer register is built.

Structure
REQ-029 `MEMORY_SIZE_BITS and the 3-bit colour width come from the shared header.v; FSM encodings are local parameters.
REQ-030 The winner selection is a sub-module, arb_pick (inputs: req and pointer; output: one-hot winner); it is purely combinational.

Verification
REQ-031 Single request: req=3'b001, wen_in[0]=1, addr 5,6,7 on consecutive cycles, then req drops -> grant=001 one cycle after req; address 5,6,7 with print_enable 1, each one cycle delayed; then grant=000 and print_enable 0 for 1 GAP cycle.
REQ-032 Simultaneous requests: req=3'b111 held throughout, each requester drops req after 4 cycles of grant -> with RR_EN, grant order 001,010,100,001; without RR_EN, 001 repeats as long as req[0] stays high.
REQ-033 No preemption: req[2] granted, req[0] raised mid-burst -> grant stays 100 until req[2] drops; 001 follows after the GAP.
REQ-034 Non-granted wen ignored: grant=001, wen_in[1]=1 with addr_in[1]=99 -> address never equals 99 and no extra print_enable pulse.
REQ-035 Async reset mid-burst: Reset=0 between clock edges during GRANT -> grant, print_enable, address and color become 0 immediately; after Reset=1, a pending req=010 is granted one cycle later (pointer back to 0).
REQ-036 Immediate drop: req[1] high for 1 cycle only -> grant=010 for exactly one cycle, zero print_enable pulses, busy covers GRANT plus GAP_CYCLES.
